// File: rtl/cpu_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cpu_monitor
// Brief    : Byte-stream host controller that loads and reads the shared memory
//            and starts/halts the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_monitor #(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  output logic [addr_width-1:0] start_address,
  input  logic                  cpu_halted,
  output logic                  mem_owner,
  output logic [addr_width-1:0] mon_raddr,
  output logic [addr_width-1:0] mon_waddr,
  output logic [7:0]            mon_data_in,
  output logic                  mon_write,
  input  logic [7:0]            mon_data_out
);

  localparam logic [3:0] c_st_idle    = 4'd0;
  localparam logic [3:0] c_st_args    = 4'd1;
  localparam logic [3:0] c_st_ldata   = 4'd2;
  localparam logic [3:0] c_st_lwr     = 4'd3;
  localparam logic [3:0] c_st_raddr   = 4'd4;
  localparam logic [3:0] c_st_rwait   = 4'd5;
  localparam logic [3:0] c_st_rsample = 4'd6;
  localparam logic [3:0] c_st_rsend   = 4'd7;
  localparam logic [3:0] c_st_grst1   = 4'd8;
  localparam logic [3:0] c_st_grst2   = 4'd9;
  localparam logic [3:0] c_st_hpulse  = 4'd10;
  localparam logic [3:0] c_st_hwait   = 4'd11;
  localparam logic [3:0] c_st_reply   = 4'd12;

  localparam logic [7:0] c_op_l = 8'h4C;
  localparam logic [7:0] c_op_r = 8'h52;
  localparam logic [7:0] c_op_g = 8'h47;
  localparam logic [7:0] c_op_h = 8'h48;
  localparam logic [7:0] c_op_s = 8'h53;
  localparam logic [7:0] c_rsp_k = 8'h4B;
  localparam logic [7:0] c_rsp_e = 8'h45;
  localparam logic [7:0] c_rsp_q = 8'h3F;
  localparam logic [addr_width-1:0] c_addr_one = 1;

  logic [3:0]            r_state;
  logic [7:0]            r_op;
  logic [1:0]            r_argcnt;
  logic [31:0]           r_args;
  logic                  r_err;
  logic [addr_width-1:0] r_addr;
  logic [15:0]           r_len;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic [addr_width-1:0] r_start_address;
  logic [addr_width-1:0] r_raddr;
  logic [addr_width-1:0] r_waddr;
  logic [7:0]            r_wdata;
  logic                  r_cpu_reset;
  logic                  r_mem_owner;

  logic        w_running;
  logic        w_args_last;
  logic [31:0] w_args_nxt;
  logic        w_g_fire;
  logic        w_cpu_reset_nxt;
  logic        w_unused;

  assign w_running   = !r_cpu_reset && !cpu_halted;
  assign w_args_nxt  = {r_args[23:0], rx_data};
  assign w_args_last = (r_op == c_op_g) ? (r_argcnt == 2'd1) : (r_argcnt == 2'd3);
  assign w_unused    = ^{r_args[31:24], w_args_nxt};

  // cpu_reset is computed one step ahead so mem_owner can fall on the same edge.
  assign w_g_fire = (r_state == c_st_args) && rx_valid && w_args_last &&
                    (r_op == c_op_g) && !r_err;
  assign w_cpu_reset_nxt = w_g_fire ? 1'b1 :
                           (r_state == c_st_grst2) ? 1'b0 : r_cpu_reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_reset <= 1'b1;
      r_mem_owner <= 1'b1;
    end else begin
      r_cpu_reset <= w_cpu_reset_nxt;
      r_mem_owner <= w_cpu_reset_nxt || cpu_halted;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= c_st_idle;
      r_op            <= 8'h00;
      r_argcnt        <= 2'd0;
      r_args          <= 32'h0;
      r_err           <= 1'b0;
      r_addr          <= '0;
      r_len           <= 16'h0;
      r_tx_data       <= 8'h00;
      r_tx_valid      <= 1'b0;
      r_start_address <= '0;
      r_raddr         <= '0;
      r_waddr         <= '0;
      r_wdata         <= 8'h00;
    end else begin
      case (r_state)
        c_st_idle: if (rx_valid) begin
          r_op     <= rx_data;
          r_argcnt <= 2'd0;
          r_err    <= w_running;
          if (rx_data == c_op_l || rx_data == c_op_r || rx_data == c_op_g) begin
            r_state <= c_st_args;
          end else if (rx_data == c_op_h && w_running) begin
            r_state <= c_st_hpulse;
          end else begin
            r_tx_data  <= (rx_data == c_op_h) ? c_rsp_k :
                          (rx_data == c_op_s) ? {6'b0, w_running, cpu_halted} : c_rsp_q;
            r_tx_valid <= 1'b1;
            r_state    <= c_st_reply;
          end
        end
        c_st_args: if (rx_valid) begin
          r_args   <= w_args_nxt;
          r_argcnt <= r_argcnt + 2'd1;
          if (w_args_last) begin
            if (r_op == c_op_g) begin
              if (r_err) begin
                r_tx_data  <= c_rsp_e;
                r_tx_valid <= 1'b1;
                r_state    <= c_st_reply;
              end else begin
                r_start_address <= w_args_nxt[addr_width-1:0];
                r_state         <= c_st_grst1;
              end
            end else begin
              r_addr <= w_args_nxt[16 +: addr_width];
              r_len  <= w_args_nxt[15:0];
              // A refused load still walks its payload so the stream stays aligned.
              if (r_op == c_op_l && w_args_nxt[15:0] != 16'h0) begin
                r_state <= c_st_ldata;
              end else if (r_op == c_op_l || r_err) begin
                r_tx_data  <= r_err ? c_rsp_e : c_rsp_k;
                r_tx_valid <= 1'b1;
                r_state    <= c_st_reply;
              end else begin
                r_state <= (w_args_nxt[15:0] == 16'h0) ? c_st_idle : c_st_raddr;
              end
            end
          end
        end
        c_st_ldata: if (rx_valid) begin
          r_waddr <= r_addr;
          r_wdata <= rx_data;
          r_state <= c_st_lwr;
        end
        c_st_lwr: begin
          r_addr <= r_addr + c_addr_one;
          r_len  <= r_len - 16'd1;
          if (r_len == 16'd1) begin
            r_tx_data  <= r_err ? c_rsp_e : c_rsp_k;
            r_tx_valid <= 1'b1;
            r_state    <= c_st_reply;
          end else begin
            r_state <= c_st_ldata;
          end
        end
        c_st_raddr: begin
          r_raddr <= r_addr;
          r_state <= c_st_rwait;
        end
        c_st_rwait:   r_state <= c_st_rsample;
        c_st_rsample: begin
          r_tx_data  <= mon_data_out;
          r_tx_valid <= 1'b1;
          r_state    <= c_st_rsend;
        end
        c_st_rsend: if (tx_ready) begin
          r_tx_valid <= 1'b0;
          r_addr     <= r_addr + c_addr_one;
          r_len      <= r_len - 16'd1;
          r_state    <= (r_len == 16'd1) ? c_st_idle : c_st_raddr;
        end
        c_st_grst1: r_state <= c_st_grst2;
        c_st_grst2: begin
          r_tx_data  <= c_rsp_k;
          r_tx_valid <= 1'b1;
          r_state    <= c_st_reply;
        end
        c_st_hpulse: r_state <= c_st_hwait;
        c_st_hwait: if (cpu_halted) begin
          r_tx_data  <= c_rsp_k;
          r_tx_valid <= 1'b1;
          r_state    <= c_st_reply;
        end
        c_st_reply: if (tx_ready) begin
          r_tx_valid <= 1'b0;
          r_state    <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign rx_ready      = !reset && (r_state == c_st_idle || r_state == c_st_args ||
                                    r_state == c_st_ldata);
  assign tx_data       = r_tx_data;
  assign tx_valid      = r_tx_valid;
  assign cpu_reset     = r_cpu_reset;
  assign cpu_halt      = (r_state == c_st_hpulse);
  assign start_address = r_start_address;
  assign mem_owner     = r_mem_owner;
  assign mon_raddr     = r_raddr;
  assign mon_waddr     = r_waddr;
  assign mon_data_in   = r_wdata;
  assign mon_write     = (r_state == c_st_lwr) && !r_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_monitor
// Brief    : Directed self-checking bench for cpu_monitor with a byte memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       cpu_reset;
  logic       cpu_halt;
  logic [8:0] start_address;
  logic       cpu_halted = 1'b0;
  logic       mem_owner;
  logic [8:0] mon_raddr;
  logic [8:0] mon_waddr;
  logic [7:0] mon_data_in;
  logic       mon_write;
  logic [7:0] mon_data_out = 8'h00;

  logic [7:0] mem [0:511];
  int         wr_count = 0;
  int         halt_count = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] b;

  cpu_monitor #(.addr_width(9)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .start_address(start_address),
    .cpu_halted(cpu_halted), .mem_owner(mem_owner),
    .mon_raddr(mon_raddr), .mon_waddr(mon_waddr), .mon_data_in(mon_data_in),
    .mon_write(mon_write), .mon_data_out(mon_data_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read byte memory, plus strobe counters.
  always @(posedge clk) begin
    if (mon_write) mem[mon_waddr] <= mon_data_in;
    mon_data_out <= mem[mon_raddr];
    if (mon_write) wr_count <= wr_count + 1;
    if (cpu_halt) halt_count <= halt_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    rx_data  = d;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=no_rx_ready expected=rx_ready byte=%0h", d);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic recv(output logic [7:0] d, input int max_stall);
    int n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    d = tx_data;
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL recv_timeout observed=no_tx_valid expected=tx_valid");
      d = 8'hxx;
    end else begin
      repeat ($urandom_range(0, max_stall)) @(negedge clk);
      check("tx_hold", {tx_valid, tx_data}, {1'b1, d});
      tx_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_ready = 1'b0;
    end
  endtask

  task automatic expect_reply(input string tag, input logic [7:0] exp, input int max_stall);
    logic [7:0] got;
    recv(got, max_stall);
    check(tag, got, exp);
  endtask

  initial begin
    int w0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_mem_owner", mem_owner, 1'b1);
    check("rst_tx", {tx_valid, tx_data}, 9'h000);
    check("rst_misc", {cpu_halt, mon_write, start_address}, 11'h000);
    check("rst_addrs", {mon_raddr, mon_waddr, mon_data_in}, 26'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", rx_ready, 1'b1);

    send(8'h53);
    expect_reply("status_reset", 8'h00, 0);

    // Load three bytes, then read them back with stalls
    send(8'h4C); send(8'h00); send(8'h10); send(8'h00); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
    expect_reply("load_k", 8'h4B, 2);
    check("mem10", mem[9'h010], 8'hAA);
    check("mem11", mem[9'h011], 8'hBB);
    check("mem12", mem[9'h012], 8'hCC);
    check("load_wr_count", wr_count, 3);

    send(8'h52); send(8'h00); send(8'h10); send(8'h00); send(8'h03);
    expect_reply("read0", 8'hAA, 3);
    expect_reply("read1", 8'hBB, 3);
    expect_reply("read2", 8'hCC, 3);
    repeat (10) @(negedge clk);
    check("read_no_k", tx_valid, 1'b0);

    // Address wrap and zero-length load
    send(8'h4C); send(8'h01); send(8'hFF); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22);
    expect_reply("wrap_k", 8'h4B, 0);
    check("mem1ff", mem[9'h1FF], 8'h11);
    check("mem000", mem[9'h000], 8'h22);
    w0 = wr_count;
    send(8'h4C); send(8'h00); send(8'h20); send(8'h00); send(8'h00);
    expect_reply("len0_k", 8'h4B, 0);
    check("len0_no_write", wr_count, w0);

    // Go: cpu_reset high through two cycles, then released with mem_owner
    send(8'h47); send(8'h00); send(8'h04);
    check("go_start_addr", start_address, 9'h004);
    check("go_rst_c1", cpu_reset, 1'b1);
    @(negedge clk);
    check("go_rst_c2", cpu_reset, 1'b1);
    check("go_owner_c2", mem_owner, 1'b1);
    @(negedge clk);
    check("go_rst_drop", cpu_reset, 1'b0);
    check("go_owner_drop", mem_owner, 1'b0);
    expect_reply("go_k", 8'h4B, 0);
    send(8'h53);
    expect_reply("status_run", 8'h02, 0);

    // Refused commands while running
    w0 = wr_count;
    send(8'h4C); send(8'h00); send(8'h10); send(8'h00); send(8'h02);
    send(8'h55); send(8'h66);
    expect_reply("run_load_e", 8'h45, 0);
    check("run_load_nowr", wr_count, w0);
    check("run_mem10", mem[9'h010], 8'hAA);
    send(8'h52); send(8'h00); send(8'h10); send(8'h00); send(8'h01);
    expect_reply("run_read_e", 8'h45, 0);
    send(8'h47); send(8'h00); send(8'h08);
    expect_reply("run_go_e", 8'h45, 0);
    check("run_go_keep", {start_address, cpu_reset}, {9'h004, 1'b0});

    // Halt handshake
    send(8'h48);
    check("halt_pulse", cpu_halt, 1'b1);
    @(negedge clk);
    check("halt_pulse_end", cpu_halt, 1'b0);
    repeat (4) @(negedge clk);
    check("halt_wait", {tx_valid, cpu_halt}, 2'b00);
    cpu_halted = 1'b1;
    @(negedge clk);
    check("halt_owner", mem_owner, 1'b1);
    expect_reply("halt_k", 8'h4B, 0);
    send(8'h53);
    expect_reply("status_halt", 8'h01, 0);
    send(8'h48);
    expect_reply("halt_idle_k", 8'h4B, 0);
    check("halt_pulses", halt_count, 1);

    send(8'h7A);
    expect_reply("unknown_q", 8'h3F, 0);

    // Reset in the middle of a load payload
    send(8'h4C); send(8'h00); send(8'h30); send(8'h00); send(8'h04);
    send(8'h01); send(8'h02);
    reset = 1'b1;
    cpu_halted = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_cpu_reset", cpu_reset, 1'b1);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_reply", tx_valid, 1'b0);
    check("abort_owner", mem_owner, 1'b1);
    send(8'h53);
    expect_reply("status_abort", 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/cpu_monitor.md
# cpu_monitor

Host-side controller for the other end of the CPU's control and memory interface. It takes a byte-stream command link (UART-style valid/ready) and uses it to load program bytes into the shared byte memory, set the CPU start address, release the CPU from reset, request a halt and wait for the register dump, and read memory back. It owns the memory port whenever the CPU is held in reset or has halted; a top-level mux selects between CPU and monitor memory signals using `mem_owner`.

## Interface
- `addr_width`, default 9: memory address width; must match the CPU.
- `clk`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  command byte from host.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  monitor accepts a byte; a transfer occurs on an edge where `rx_valid` and `rx_ready` are both high.
- `tx_data`  out  8  reply byte to host.
- `tx_valid`  out  1  `tx_data` is valid; held with stable data until `tx_ready`.
- `tx_ready`  in  1  host accepts the reply byte.
- `cpu_reset`  out  1  drives the CPU `reset` input.
- `cpu_halt`  out  1  drives the CPU `halt` input; always a single-cycle pulse.
- `start_address`  out  addr_width  CPU start address.
- `cpu_halted`  in  1  CPU `halted` output.
- `mem_owner`  out  1  1 means the monitor drives memory; 0 means the CPU does.
- `mon_raddr`, `mon_waddr`  out  addr_width  monitor read and write addresses.
- `mon_data_in`  out  8  write data to memory.
- `mon_write`  out  1  one-cycle write strobe.
- `mon_data_out`  in  8  read data from memory.

## Operation
- `running` = `!cpu_reset && !cpu_halted`. `mem_owner` = `!running`, registered.
- All multi-byte fields are big-endian.
- Addresses wrap modulo 2^addr_width. Lengths are 16-bit; a length of 0 transfers nothing.
- Commands:
  - `0x4C` 'L' a_hi a_lo n_hi n_lo, then n data bytes: writes the bytes to consecutive addresses and replies `0x4B` 'K'.
  - `0x52` 'R' a_hi a_lo n_hi n_lo: replies with n memory bytes from consecutive addresses. No 'K' follows.
  - `0x47` 'G' a_hi a_lo: sets `start_address`, holds `cpu_reset` high for 2 cycles, drops it, then replies 'K'.
  - `0x48` 'H': pulses `cpu_halt` for 1 cycle, waits for `cpu_halted`=1, then replies 'K'. If not running, replies 'K' at once with no pulse.
  - `0x53` 'S': replies {6'b0, running, cpu_halted}.
  - Any other byte: replies `0x3F` '?'.
- While running, 'L', 'R' and 'G' reply `0x45` 'E' instead of acting:
  - 'L' still consumes all n payload bytes (without writing) before replying, so the stream stays in sync.
  - 'R' and 'G' reply after their parameter bytes.
- State machine:
  - IDLE: `rx_ready`=1; the opcode byte selects the next state.
  - ARGS: `rx_ready`=1; collects 2 or 4 parameter bytes.
  - LDATA → LWR: loops per data byte.
  - RADDR → RWAIT → RSAMPLE → RSEND: loops per read byte.
  - GRST1 → GRST2.
  - HPULSE → HWAIT.
  - REPLY → IDLE.
- Write path:
  - A byte accepted in LDATA at edge e sets `mon_waddr`=addr and `mon_data_in`=byte.
  - LWR asserts `mon_write` during the cycle after e, then increments addr, decrements the count, and returns to LDATA, or to REPLY when the count reaches 0.
  - `rx_ready`=0 in LWR.
- Read path: RADDR sets `mon_raddr`; RWAIT idles one cycle; RSAMPLE latches `mon_data_out` into `tx_data` and sets `tx_valid`; RSEND holds until `tx_ready`.

## Timing
- Reset values:
  - `cpu_reset`=1, `cpu_halt`=0, `start_address`=0, `mem_owner`=1.
  - `rx_ready`=0 in the reset cycle, then 1 in IDLE.
  - `tx_valid`=0, `tx_data`=0, `mon_write`=0, `mon_raddr`=`mon_waddr`=`mon_data_in`=0, state IDLE.
- Memory read latency: data is sampled on the second edge after `mon_raddr` updates.
- Load throughput: one byte per 2 cycles at most.
- Read throughput: one byte per 3 cycles plus the `tx_ready` wait.
- `mem_owner` falls on the same edge `cpu_reset` falls. It rises one cycle after `cpu_halted` rises.
- `cpu_halt` never stays high more than 1 cycle; a held halt would stall the CPU in its dump loop.
- HWAIT has no timeout.
- `reset` mid-command aborts everything: partial arguments are discarded, no reply is sent, and the CPU is held in reset again.
- Bytes offered while `rx_ready`=0 are simply not taken. The monitor never drops a handshaked byte.

## Test plan
- Reset, then 'S' → reply `0x00`; `cpu_reset`=1; `mem_owner`=1.
- 'L' 0x00 0x10 0x00 0x03 AA BB CC → memory[0x10..0x12]=AA,BB,CC; reply 'K'. Then 'R' 0x00 0x10 0x00 0x03 → replies AA,BB,CC with random `tx_ready` stalls.
- 'L' 0x01 0xFF 0x00 0x02 11 22 with addr_width=9 → writes 0x1FF=11 and 0x000=22 (wrap); n=0 replies 'K' with no `mon_write`.
- 'G' 0x00 0x04 → `start_address`=4, `cpu_reset` high exactly 2 cycles, 'K'. Then 'S' → `0x02`. Then 'L' … → consumes the payload, 'E', memory unchanged.
- While running, 'H' → one-cycle `cpu_halt`, 'K' only after `cpu_halted`; 'S' → `0x01`; `mem_owner`=1.
- Opcode `0x7A` → '?'. Assert `reset` in the middle of an 'L' payload → no reply, `cpu_reset`=1, next 'S' → `0x00`.
